matmul_stream_engine: RTL and testbench

Parametrised successor to the fixed-size pipelined matrix multiplier. It computes C = A x B for an MxK by KxN matrix pair and supports signed or unsigned operands. Operands stream in on one valid/ready port and results stream out on a second valid/ready port that honours backpressure. A single row of N MAC lanes is time-multiplexed over the M rows, so area scales with N rather than M*N.

---
 rtl/matmul_stream_engine.sv | 189 ++++++++++++++++++
 tb/tb_matmul_stream_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_engine.sv
// Streaming C = A x B engine: one row of N MAC lanes reused across the M rows of A.
// Define MMS_SATURATE_EN to clamp results to the OW range instead of wrapping.
module matmul_stream_engine #(
   parameter int unsigned M      = 3,
   parameter int unsigned K      = 3,
   parameter int unsigned N      = 3,
   parameter int unsigned DW     = 8,
   parameter int unsigned OW     = 16,
   parameter int unsigned SIGNED = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   localparam int unsigned ACCW = 2 * DW + $clog2(K);
   localparam int unsigned WW   = ((ACCW > OW) ? ACCW : OW) + 1;
   localparam int unsigned AD   = M * K;
   localparam int unsigned BD   = K * N;
   localparam int unsigned LD   = (AD > BD) ? AD : BD;
   localparam int unsigned AIW  = (AD > 1) ? $clog2(AD) : 1;
   localparam int unsigned BIW  = (BD > 1) ? $clog2(BD) : 1;
   localparam int unsigned LW   = (LD > 1) ? $clog2(LD) : 1;
   localparam int unsigned IW   = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned JW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW   = $clog2(K + 1);

   localparam logic [WW-1:0] UMAX = {{(WW - OW){1'b0}}, {OW{1'b1}}};
   localparam logic [WW-1:0] SMAX = {{(WW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic [WW-1:0] SMIN = {{(WW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StEmit} state_e;

   state_e          state_q;
   logic [LW-1:0]   ld_q;
   logic [IW-1:0]   i_q;
   logic [JW-1:0]   j_q;
   logic [CW-1:0]   c_q;

   logic [DW-1:0]   a_buf  [AD];
   logic [DW-1:0]   b_buf  [BD];
   logic [ACCW-1:0] prod_q [N];
   logic [ACCW-1:0] acc_q  [N];
   logic [OW-1:0]   obuf_q [N];

   logic [CW-1:0]   k_idx;
   logic [ACCW-1:0] a_op;
   logic [ACCW-1:0] prod_d [N];
   logic [ACCW-1:0] sum    [N];
   logic [OW-1:0]   res    [N];

   function automatic logic [ACCW-1:0] ext_op(input logic [DW-1:0] x);
      if (SIGNED != 0) ext_op = {{(ACCW - DW){x[DW-1]}}, x};
      else             ext_op = {{(ACCW - DW){1'b0}}, x};
   endfunction

   // Widen past both ACCW and OW so clamp compares never lose the sign.
   function automatic logic [OW-1:0] conv(input logic [ACCW-1:0] s);
      logic [WW-1:0] w;
      if (SIGNED != 0) w = {{(WW - ACCW){s[ACCW-1]}}, s};
      else             w = {{(WW - ACCW){1'b0}}, s};
`ifdef MMS_SATURATE_EN
      if (SIGNED != 0) begin
         if ($signed(w) > $signed(SMAX))      w = SMAX;
         else if ($signed(w) < $signed(SMIN)) w = SMIN;
      end else if (w > UMAX) begin
         w = UMAX;
      end
`endif
      conv = w[OW-1:0];
   endfunction

   always_comb begin
      k_idx = (c_q < CW'(K)) ? c_q : '0;
      a_op  = ext_op(a_buf[AIW'(i_q * K + k_idx)]);
      for (int j = 0; j < N; j++) begin
         prod_d[j] = a_op * ext_op(b_buf[BIW'(k_idx * N + j)]);
         sum[j]    = acc_q[j] + prod_q[j];
         res[j]    = conv(sum[j]);
      end
   end

   // Operand buffers and lane pipeline carry no reset; their contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if (state_q == StLoadA && in_valid) a_buf[AIW'(ld_q)] <= in_data;
      if (state_q == StLoadB && in_valid) b_buf[BIW'(ld_q)] <= in_data;
      if (state_q == StCompute) begin
         for (int j = 0; j < N; j++) begin
            prod_q[j] <= prod_d[j];
            acc_q[j]  <= (c_q == '0) ? '0 : sum[j];
            if (c_q == CW'(K)) obuf_q[j] <= res[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ld_q      <= '0;
         i_q       <= '0;
         j_q       <= '0;
         c_q       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StLoadA;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  ld_q     <= '0;
                  i_q      <= '0;
               end
            end
            StLoadA: begin
               if (in_valid) begin
                  if (ld_q == LW'(AD - 1)) begin
                     ld_q    <= '0;
                     state_q <= StLoadB;
                  end else begin
                     ld_q <= ld_q + 1'b1;
                  end
               end
            end
            StLoadB: begin
               if (in_valid) begin
                  if (ld_q == LW'(BD - 1)) begin
                     ld_q     <= '0;
                     in_ready <= 1'b0;
                     c_q      <= '0;
                     state_q  <= StCompute;
                  end else begin
                     ld_q <= ld_q + 1'b1;
                  end
               end
            end
            StCompute: begin
               if (c_q == CW'(K)) begin
                  c_q       <= '0;
                  j_q       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= res[0];
                  out_last  <= (i_q == IW'(M - 1)) && (N == 1);
                  state_q   <= StEmit;
               end else begin
                  c_q <= c_q + 1'b1;
               end
            end
            StEmit: begin
               if (out_ready) begin
                  if (j_q == JW'(N - 1)) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (i_q == IW'(M - 1)) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        i_q     <= i_q + 1'b1;
                        state_q <= StCompute;
                     end
                  end else begin
                     j_q      <= j_q + 1'b1;
                     out_data <= obuf_q[JW'(j_q + 1'b1)];
                     out_last <= (i_q == IW'(M - 1)) && ((j_q + 1'b1) == JW'(N - 1));
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Randomised directed bench for matmul_stream_engine: unsigned and signed instances
// checked against an integer reference of C = A x B.
module tb_matmul_stream_engine;

   localparam int M = 3, K = 3, N = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_s     [2];
   logic       in_valid_s  [2];
   logic [7:0] in_data_s   [2];
   logic       out_ready_s [2];
   logic       in_ready_s  [2];
   logic       out_valid_s [2];
   logic       out_last_s  [2];
   logic       busy_s      [2];
   logic       done_s      [2];
   logic [15:0] out_data_s [2];

   int n_vec = 0;
   int n_err = 0;
   int a_m [M*K];
   int b_m [K*N];
   int sq [$];

   always #5 clk = ~clk;

   matmul_stream_engine #(.SIGNED(0)) dut_u (
      .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
      .in_ready(in_ready_s[0]), .in_data(in_data_s[0]), .out_valid(out_valid_s[0]),
      .out_ready(out_ready_s[0]), .out_data(out_data_s[0]), .out_last(out_last_s[0]),
      .busy(busy_s[0]), .done(done_s[0])
   );

   matmul_stream_engine #(.SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
      .in_ready(in_ready_s[1]), .in_data(in_data_s[1]), .out_valid(out_valid_s[1]),
      .out_ready(out_ready_s[1]), .out_data(out_data_s[1]), .out_last(out_last_s[1]),
      .busy(busy_s[1]), .done(done_s[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int opv(input int u, input int x);
      int v;
      v = x & 255;
      if (u == 1 && v >= 128) v -= 256;
      return v;
   endfunction

   // Exact dot product, then clamp or wrap to 16 bits.
   function automatic logic [15:0] ref_elem(input int u, input int i, input int j);
      longint s;
      s = 0;
      for (int k = 0; k < K; k++) s += longint'(opv(u, a_m[i*K+k])) * longint'(opv(u, b_m[k*N+j]));
`ifdef MMS_SATURATE_EN
      if (u == 1) begin
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
      end else if (s > 65535) begin
         s = 65535;
      end
`endif
      return s[15:0];
   endfunction

   task automatic feed(input int u, input int n, input bit gaps);
      int idx, guard;
      idx = 0;
      guard = 0;
      while (idx < n && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (gaps && ($urandom % 3 == 0)) begin
            in_valid_s[u] = 1'b0;
            in_data_s[u]  = 8'($urandom);
         end else begin
            in_valid_s[u] = 1'b1;
            in_data_s[u]  = 8'(sq[idx]);
            if (in_ready_s[u]) idx++;
         end
      end
      if (idx != n) chk("feed_timeout", 32'(idx), 32'(n));
   endtask

   task automatic do_job(input int u, input int rmode, input bit gaps, input bit poke,
                         input bit chain_in, input bit chain_out);
      int beats, w, guard, rc;
      bit first, r;
      sq.delete();
      foreach (a_m[x]) sq.push_back(a_m[x]);
      foreach (b_m[x]) sq.push_back(b_m[x]);
      if (!chain_in) begin
         @(negedge clk);
         start_s[u] = 1'b1;
      end
      @(negedge clk);
      start_s[u] = 1'b0;
      chk("load_ready", 32'(in_ready_s[u]), 32'd1);
      chk("load_busy", 32'(busy_s[u]), 32'd1);
      feed(u, M*K + K*N, gaps);
      beats = 0; w = 0; guard = 0; rc = 0; first = 1'b1;
      while (beats < M*N && guard < 500) begin
         @(negedge clk);
         in_valid_s[u] = 1'b0;
         guard++;
         if (poke) start_s[u] = (guard == 2);
         if (first) w++;
         chk("done_early", 32'(done_s[u]), 32'd0);
         if (out_valid_s[u]) begin
            if (first) chk("latency", 32'(w), 32'(K + 2));
            first = 1'b0;
            chk("data", 32'(out_data_s[u]), 32'(ref_elem(u, beats / N, beats % N)));
            chk("last", 32'(out_last_s[u]), 32'(beats == M*N - 1));
            r = (rmode == 0) ? 1'b1 : (rc % 3 == 0);
            rc++;
            out_ready_s[u] = r;
            if (r) beats++;
         end else begin
            out_ready_s[u] = 1'($urandom);
         end
      end
      chk("beats", 32'(beats), 32'(M*N));
      @(negedge clk);
      out_ready_s[u] = 1'b0;
      chk("done_pulse", 32'(done_s[u]), 32'd1);
      chk("idle_valid", 32'(out_valid_s[u]), 32'd0);
      chk("idle_busy", 32'(busy_s[u]), 32'd0);
      if (chain_out) begin
         start_s[u] = 1'b1;
      end else begin
         @(negedge clk);
         chk("done_single", 32'(done_s[u]), 32'd0);
      end
   endtask

   task automatic set_ident_b();
      foreach (b_m[x]) b_m[x] = (x / N == x % N) ? 1 : 0;
   endtask

   task automatic set_rand();
      foreach (a_m[x]) a_m[x] = int'($urandom_range(255));
      foreach (b_m[x]) b_m[x] = int'($urandom_range(255));
   endtask

   initial begin
      reset = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start_s[u] = 1'b0; in_valid_s[u] = 1'b0; in_data_s[u] = '0; out_ready_s[u] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_busy", 32'(busy_s[u]), 32'd0);
         chk("rst_in_ready", 32'(in_ready_s[u]), 32'd0);
         chk("rst_out_valid", 32'(out_valid_s[u]), 32'd0);
         chk("rst_out_last", 32'(out_last_s[u]), 32'd0);
         chk("rst_done", 32'(done_s[u]), 32'd0);
         chk("rst_out_data", 32'(out_data_s[u]), 32'd0);
      end
      reset = 1'b1;

      // Identity, unsigned
      foreach (a_m[x]) a_m[x] = x + 1;
      set_ident_b();
      do_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Unsigned overflow
      foreach (a_m[x]) a_m[x] = 255;
      foreach (b_m[x]) b_m[x] = 255;
      do_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Identity under backpressure and input gaps
      foreach (a_m[x]) a_m[x] = x + 1;
      set_ident_b();
      do_job(0, 1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Random operands, with and without stalls
      for (int t = 0; t < 4; t++) begin
         set_rand();
         do_job(0, t % 2, 1'(t % 2), 1'b0, 1'b0, 1'b0);
      end

      // Reset part-way through loading A
      set_rand();
      sq.delete();
      foreach (a_m[x]) sq.push_back(a_m[x]);
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      feed(0, 4, 1'b0);
      @(negedge clk);
      in_valid_s[0] = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy_s[0]), 32'd0);
      chk("midrst_in_ready", 32'(in_ready_s[0]), 32'd0);
      chk("midrst_out_valid", 32'(out_valid_s[0]), 32'd0);
      chk("midrst_done", 32'(done_s[0]), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_no_done", 32'(done_s[0]), 32'd0);
      set_rand();
      do_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start during COMPUTE is ignored
      set_rand();
      do_job(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("poke_idle", 32'(busy_s[0]), 32'd0);

      // Back-to-back jobs: start in the done cycle
      set_rand();
      do_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      set_rand();
      do_job(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Signed overflow
      foreach (a_m[x]) a_m[x] = 8'h80;
      foreach (b_m[x]) b_m[x] = 8'h80;
      do_job(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Signed row {-1,2,-3} times identity
      set_rand();
      a_m[0] = 8'hFF; a_m[1] = 2; a_m[2] = 8'hFD;
      set_ident_b();
      do_job(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random signed with stalls
      for (int t = 0; t < 3; t++) begin
         set_rand();
         do_job(1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
